// File: rtl/sparc_cc_pkg.sv
// Shared constants for the SPARC condition-code execute stage:
// data/flag widths, flag bit positions inside {N,Z,V,C} and Bicc cond encodings.
package sparc_cc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned COND_W = 4;
    localparam int unsigned PERF_W = 32;

    // Flag bit positions inside icc / alu_flags
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // Bicc cond field encodings
    localparam logic [3:0] COND_NEVER  = 4'b0000;
    localparam logic [3:0] COND_E      = 4'b0001;
    localparam logic [3:0] COND_LE     = 4'b0010;
    localparam logic [3:0] COND_L      = 4'b0011;
    localparam logic [3:0] COND_LEU    = 4'b0100;
    localparam logic [3:0] COND_CS     = 4'b0101;
    localparam logic [3:0] COND_NEG    = 4'b0110;
    localparam logic [3:0] COND_VS     = 4'b0111;
    localparam logic [3:0] COND_ALWAYS = 4'b1000;
    localparam logic [3:0] COND_NE     = 4'b1001;
    localparam logic [3:0] COND_G      = 4'b1010;
    localparam logic [3:0] COND_GE     = 4'b1011;
    localparam logic [3:0] COND_GU     = 4'b1100;
    localparam logic [3:0] COND_CC     = 4'b1101;
    localparam logic [3:0] COND_POS    = 4'b1110;
    localparam logic [3:0] COND_VC     = 4'b1111;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational Bicc condition evaluator: decides branch taken from icc and cond.
module cc_cond_eval
    import sparc_cc_pkg::*;
(
    input  logic [FLAG_W-1:0] icc,
    input  logic [COND_W-1:0] cond,
    output logic              taken
);

    logic n_s;
    logic z_s;
    logic v_s;
    logic c_s;

    assign n_s = icc[FLAG_N];
    assign z_s = icc[FLAG_Z];
    assign v_s = icc[FLAG_V];
    assign c_s = icc[FLAG_C];

    // Decode the cond field against the current flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_E:      taken = z_s;
            COND_LE:     taken = z_s | (n_s ^ v_s);
            COND_L:      taken = n_s ^ v_s;
            COND_LEU:    taken = c_s | z_s;
            COND_CS:     taken = c_s;
            COND_NEG:    taken = n_s;
            COND_VS:     taken = v_s;
            COND_ALWAYS: taken = 1'b1;
            COND_NE:     taken = ~z_s;
            COND_G:      taken = ~(z_s | (n_s ^ v_s));
            COND_GE:     taken = ~(n_s ^ v_s);
            COND_GU:     taken = ~(c_s | z_s);
            COND_CC:     taken = ~c_s;
            COND_POS:    taken = ~n_s;
            COND_VC:     taken = ~v_s;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cc_stage.sv
// Execute-stage pipeline register with SPARC integer condition codes.
// Holds one ALU result word for the MEM stage, owns the architectural icc,
// and resolves Bicc branches against the icc value seen before any update
// made by the same word.
// Optional performance counters are built when EX_CC_PERF_EN is defined;
// otherwise perf_words/perf_taken are tied to zero.
module ex_cc_stage
    import sparc_cc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              modcc,
    input  logic [REG_W-1:0]  rd,
    input  logic              wr_en,
    input  logic              is_branch,
    input  logic [COND_W-1:0] cond,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wr_en,
    output logic              out_taken,
    output logic [FLAG_W-1:0] icc,
    output logic              alu_cin,
    output logic [PERF_W-1:0] perf_words,
    output logic [PERF_W-1:0] perf_taken
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] y_d;
    logic [REG_W-1:0]  rd_q;
    logic [REG_W-1:0]  rd_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic              taken_q;
    logic              taken_d;
    logic [FLAG_W-1:0] icc_q;
    logic [FLAG_W-1:0] icc_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              cond_taken_s;
    logic              branch_taken_s;

    // Branch decision always uses the icc held before this edge
    cc_cond_eval u_cond_eval (
        .icc   (icc_q),
        .cond  (cond),
        .taken (cond_taken_s)
    );

    assign in_ready_s     = ~valid_q | out_ready;
    assign accept_s       = in_valid & in_ready_s & ~flush;
    assign branch_taken_s = is_branch & cond_taken_s;

    // Next-state for the held word and icc; wr_en/taken are cleared whenever the slot empties
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        rd_d    = rd_q;
        wr_en_d = wr_en_q;
        taken_d = taken_q;
        icc_d   = icc_q;
        if (flush) begin
            valid_d = 1'b0;
            wr_en_d = 1'b0;
            taken_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            y_d     = alu_y;
            rd_d    = rd;
            wr_en_d = wr_en;
            taken_d = branch_taken_s;
            if (modcc) begin
                icc_d = alu_flags;
            end else begin
                icc_d = icc_q;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            wr_en_d = 1'b0;
            taken_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register and icc state, synchronous reset has top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            y_q     <= {DATA_W{1'b0}};
            rd_q    <= {REG_W{1'b0}};
            wr_en_q <= 1'b0;
            taken_q <= 1'b0;
            icc_q   <= {FLAG_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            rd_q    <= rd_d;
            wr_en_q <= wr_en_d;
            taken_q <= taken_d;
            icc_q   <= icc_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q;
    assign out_y     = y_q;
    assign out_rd    = rd_q;
    assign out_wr_en = wr_en_q;
    assign out_taken = taken_q;
    assign icc       = icc_q;
    assign alu_cin   = icc_q[FLAG_C];

`ifdef EX_CC_PERF_EN
    logic [PERF_W-1:0] perf_words_q;
    logic [PERF_W-1:0] perf_words_d;
    logic [PERF_W-1:0] perf_taken_q;
    logic [PERF_W-1:0] perf_taken_d;

    // Count accepted words and accepted taken branches, wrapping freely
    always_comb begin
        perf_words_d = perf_words_q;
        perf_taken_d = perf_taken_q;
        if (accept_s) begin
            perf_words_d = perf_words_q + 32'd1;
            if (branch_taken_s) begin
                perf_taken_d = perf_taken_q + 32'd1;
            end else begin
                perf_taken_d = perf_taken_q;
            end
        end else begin
            perf_words_d = perf_words_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_words_q <= 32'h0000_0000;
            perf_taken_q <= 32'h0000_0000;
        end else begin
            perf_words_q <= perf_words_d;
            perf_taken_q <= perf_taken_d;
        end
    end

    assign perf_words = perf_words_q;
    assign perf_taken = perf_taken_q;
`else
    assign perf_words = 32'h0000_0000;
    assign perf_taken = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ex_cc_stage.sv
// Directed self-checking bench for ex_cc_stage (either build of EX_CC_PERF_EN).
module tb_ex_cc_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_y;
    logic [3:0]  alu_flags;
    logic        modcc;
    logic [4:0]  rd;
    logic        wr_en;
    logic        is_branch;
    logic [3:0]  cond;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic        out_taken;
    logic [3:0]  icc;
    logic        alu_cin;
    logic [31:0] perf_words;
    logic [31:0] perf_taken;

    int n_cmp;
    int n_fail;
    logic [31:0] exp_words;
    logic [31:0] exp_taken;

`ifdef EX_CC_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    ex_cc_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_y      (alu_y),
        .alu_flags  (alu_flags),
        .modcc      (modcc),
        .rd         (rd),
        .wr_en      (wr_en),
        .is_branch  (is_branch),
        .cond       (cond),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_rd     (out_rd),
        .out_wr_en  (out_wr_en),
        .out_taken  (out_taken),
        .icc        (icc),
        .alu_cin    (alu_cin),
        .perf_words (perf_words),
        .perf_taken (perf_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; alu_y = 32'hDEAD_BEEF; alu_flags = 4'b1111;
        modcc = 1'b1; rd = 5'd9; wr_en = 1'b1; is_branch = 1'b1; cond = 4'b1000;
        flush = 1'b0; out_ready = 1'b1;
        tick; tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_y !== 32'h0) begin n_fail++; $display("FAIL reset_y got=%0h exp=0", out_y); end
        n_cmp++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0h exp=0", out_rd); end
        n_cmp++; if ({out_wr_en, out_taken} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_taken got=%0b exp=00", {out_wr_en, out_taken}); end
        n_cmp++; if (icc !== 4'b0000) begin n_fail++; $display("FAIL reset_icc got=%0b exp=0000", icc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        n_cmp++; if ({perf_words, perf_taken} !== 64'h0) begin n_fail++; $display("FAIL reset_perf got=%0h/%0h exp=0/0", perf_words, perf_taken); end
        reset = 1'b0; in_valid = 1'b0; is_branch = 1'b0; modcc = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_basic;
        in_valid = 1'b1; alu_y = 32'h0000_0004; alu_flags = 4'b0100; modcc = 1'b1;
        rd = 5'd5; wr_en = 1'b1; is_branch = 1'b0; cond = 4'b1000;
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
        n_cmp++; if (out_y !== 32'h0000_0004) begin n_fail++; $display("FAIL basic_y got=%0h exp=4", out_y); end
        n_cmp++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL basic_rd got=%0d exp=5", out_rd); end
        n_cmp++; if (out_wr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr_en got=%0h exp=1", out_wr_en); end
        n_cmp++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL basic_taken_nonbranch got=%0h exp=0", out_taken); end
        n_cmp++; if (icc !== 4'b0100) begin n_fail++; $display("FAIL basic_icc got=%0b exp=0100", icc); end
        n_cmp++; if (alu_cin !== 1'b0) begin n_fail++; $display("FAIL basic_cin got=%0h exp=0", alu_cin); end
        in_valid = 1'b0;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_drain_wr_en got=%0h exp=0", out_wr_en); end
    endtask

    // icc = 4'b0100 (Z only) throughout this table
    task automatic test_cond;
        logic [3:0] conds [16];
        logic       exps  [16];
        conds = '{4'b0001, 4'b1001, 4'b0000, 4'b1000, 4'b0010, 4'b1010, 4'b0011, 4'b1011,
                  4'b0100, 4'b1100, 4'b0101, 4'b1101, 4'b0110, 4'b1110, 4'b0111, 4'b1111};
        exps  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        modcc = 1'b0; wr_en = 1'b0; is_branch = 1'b1; in_valid = 1'b1; alu_flags = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            cond = conds[i]; alu_y = 32'h100 + i;
            tick;
            exp_words = exp_words + 32'd1;
            if (exps[i]) exp_taken = exp_taken + 32'd1;
            n_cmp++; if (out_taken !== exps[i]) begin n_fail++; $display("FAIL cond_%b got=%0h exp=%0h", conds[i], out_taken, exps[i]); end
        end
        n_cmp++; if (icc !== 4'b0100) begin n_fail++; $display("FAIL cond_icc_kept got=%0b exp=0100", icc); end
        is_branch = 1'b0; cond = 4'b1000;
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL cond_not_branch got=%0h exp=0", out_taken); end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_old_icc;
        in_valid = 1'b1; is_branch = 1'b0; modcc = 1'b1; alu_flags = 4'b0000;
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if (icc !== 4'b0000) begin n_fail++; $display("FAIL oldicc_setup got=%0b exp=0000", icc); end
        is_branch = 1'b1; cond = 4'b0101; modcc = 1'b1; alu_flags = 4'b0001;
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL oldicc_taken got=%0h exp=0", out_taken); end
        n_cmp++; if (icc !== 4'b0001) begin n_fail++; $display("FAIL oldicc_icc got=%0b exp=0001", icc); end
        n_cmp++; if (alu_cin !== 1'b1) begin n_fail++; $display("FAIL oldicc_cin got=%0h exp=1", alu_cin); end
        modcc = 1'b0;
        tick;
        exp_words = exp_words + 32'd1; exp_taken = exp_taken + 32'd1;
        n_cmp++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL oldicc_newc_taken got=%0h exp=1", out_taken); end
        in_valid = 1'b0; is_branch = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back_stall;
        in_valid = 1'b1; alu_y = 32'hAAAA_5555; rd = 5'd3; wr_en = 1'b1; modcc = 1'b0; out_ready = 1'b1;
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if (out_y !== 32'hAAAA_5555) begin n_fail++; $display("FAIL stall_a_y got=%0h exp=aaaa5555", out_y); end
        out_ready = 1'b0; alu_y = 32'h1234_5678; rd = 5'd7; modcc = 1'b1; alu_flags = 4'b1010;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_comb got=%0h exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d got=%0h exp=0", i, in_ready); end
            n_cmp++; if ({out_valid, out_y, out_rd, out_wr_en} !== {1'b1, 32'hAAAA_5555, 5'd3, 1'b1})
                begin n_fail++; $display("FAIL stall_hold_%0d got=%0h/%0h/%0h exp=1/aaaa5555/3", i, out_valid, out_y, out_rd); end
            n_cmp++; if (icc !== 4'b0001) begin n_fail++; $display("FAIL stall_icc_%0d got=%0b exp=0001", i, icc); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%0h exp=1", in_ready); end
        tick;
        exp_words = exp_words + 32'd1;
        n_cmp++; if ({out_valid, out_y, out_rd} !== {1'b1, 32'h1234_5678, 5'd7})
            begin n_fail++; $display("FAIL stall_b_word got=%0h/%0h/%0h exp=1/12345678/7", out_valid, out_y, out_rd); end
        n_cmp++; if (icc !== 4'b1010) begin n_fail++; $display("FAIL stall_b_icc got=%0b exp=1010", icc); end
        in_valid = 1'b0; modcc = 1'b0;
        tick;
    endtask

    task automatic test_flush;
        in_valid = 1'b1; modcc = 1'b1; alu_flags = 4'b1000; flush = 1'b1; out_ready = 1'b1; wr_en = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (icc !== 4'b1010) begin n_fail++; $display("FAIL flush_empty_icc got=%0b exp=1010", icc); end
        n_cmp++; if (perf_words !== (PERF_ON ? exp_words : 32'h0)) begin n_fail++; $display("FAIL flush_perf got=%0h exp=%0h", perf_words, (PERF_ON ? exp_words : 32'h0)); end
        flush = 1'b0; modcc = 1'b0; alu_y = 32'h0000_00C3; rd = 5'd1;
        tick;
        exp_words = exp_words + 32'd1;
        out_ready = 1'b0; flush = 1'b1; modcc = 1'b1; alu_flags = 4'b1000;
        tick;
        n_cmp++; if ({out_valid, out_wr_en} !== 2'b00) begin n_fail++; $display("FAIL flush_held got=%0b exp=00", {out_valid, out_wr_en}); end
        n_cmp++; if (icc !== 4'b1010) begin n_fail++; $display("FAIL flush_held_icc got=%0b exp=1010", icc); end
        flush = 1'b0; in_valid = 1'b0; modcc = 1'b0; out_ready = 1'b1;
        tick;
    endtask

    task automatic test_perf;
        n_cmp++; if (perf_words !== (PERF_ON ? exp_words : 32'h0)) begin n_fail++; $display("FAIL perf_words got=%0h exp=%0h", perf_words, (PERF_ON ? exp_words : 32'h0)); end
        n_cmp++; if (perf_taken !== (PERF_ON ? exp_taken : 32'h0)) begin n_fail++; $display("FAIL perf_taken got=%0h exp=%0h", perf_taken, (PERF_ON ? exp_taken : 32'h0)); end
`ifdef EX_CC_PERF_EN
        force dut.perf_words_q = 32'hFFFF_FFFF;
        force dut.perf_taken_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_words_q;
        release dut.perf_taken_q;
`endif
        in_valid = 1'b1; is_branch = 1'b1; cond = 4'b1000; modcc = 1'b0;
        tick;
        n_cmp++; if ({perf_words, perf_taken} !== 64'h0) begin n_fail++; $display("FAIL perf_wrap got=%0h/%0h exp=0/0", perf_words, perf_taken); end
        n_cmp++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL perf_word_taken got=%0h exp=1", out_taken); end
        in_valid = 1'b0; is_branch = 1'b0;
    endtask

    task automatic test_reset_priority;
        in_valid = 1'b1; out_ready = 1'b1; alu_y = 32'h5A5A_0001; rd = 5'd30; wr_en = 1'b1; is_branch = 1'b1;
        cond = 4'b1000; modcc = 1'b0;
        tick;
        out_ready = 1'b0; reset = 1'b1; modcc = 1'b1; alu_flags = 4'b1111; flush = 1'b1;
        tick;
        n_cmp++; if ({out_valid, out_y, out_rd, out_wr_en, out_taken} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL rstprio_word got=%0h/%0h/%0h exp=0/0/0", out_valid, out_y, out_rd); end
        n_cmp++; if (icc !== 4'b0000) begin n_fail++; $display("FAIL rstprio_icc got=%0b exp=0000", icc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstprio_in_ready got=%0h exp=1", in_ready); end
        n_cmp++; if ({perf_words, perf_taken} !== 64'h0) begin n_fail++; $display("FAIL rstprio_perf got=%0h/%0h exp=0/0", perf_words, perf_taken); end
        flush = 1'b0;
        tick;
        n_cmp++; if ({out_valid, icc} !== 5'b0_0000) begin n_fail++; $display("FAIL rstprio_hold got=%0h/%0b exp=0/0000", out_valid, icc); end
        reset = 1'b0; in_valid = 1'b0;
        tick;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstprio_after_ready got=%0h exp=1", in_ready); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_words = 32'h0; exp_taken = 32'h0;
        test_reset;
        test_basic;
        test_cond;
        test_old_icc;
        test_back_to_back_stall;
        test_flush;
        test_perf;
        test_reset_priority;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
